// File: rtl/sram_like_arbiter_if.sv
// Bundled fetch, data and downstream SRAM-like buses for the arbiter.
interface sram_like_arbiter_if;
  // fetch master
  logic        i_req;
  logic        i_wr;
  logic [1:0]  i_size;
  logic [3:0]  i_wstrb;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  // load/store master
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  // downstream port
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic        busy;

  // arbiter side
  modport slave (
    input  i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output busy
  );

  // environment side (masters plus downstream bridge)
  modport master (
    output i_req, i_wr, i_size, i_wstrb, i_addr, i_wdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  busy
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like port arbiter with in-order response routing.
module sram_like_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                resetn,
  sram_like_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  logic             lock_q, lock_d;
  owner_e           lock_owner_q, lock_owner_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  owner_e gnt;
  logic   gnt_valid, req_sel, full, m_req_c, hs, pop, head_is_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant selection: held owner while locked, else data first unless fetch is starved
  always_comb begin
    gnt       = OWN_I;
    gnt_valid = 1'b0;
    if (lock_q) begin
      gnt       = lock_owner_q;
      gnt_valid = 1'b1;
    end else if (bus.d_req && !(bus.i_req && starve_q == SW'(STARVE_LIMIT))) begin
      gnt       = OWN_D;
      gnt_valid = 1'b1;
    end else if (bus.i_req) begin
      gnt       = OWN_I;
      gnt_valid = 1'b1;
    end
  end

  // Downstream request, payload mux and per-master handshake/response strobes
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    req_sel   = (gnt == OWN_D) ? bus.d_req : bus.i_req;
    // resetn gates the request so nothing is issued while reset is held
    m_req_c   = resetn & gnt_valid & req_sel & ~full;
    hs        = m_req_c & bus.m_addr_ok;
    head_is_d = fifo_q[rptr_q];
    pop       = bus.m_data_ok & (count_q != '0);

    bus.m_req   = m_req_c;
    bus.m_wr    = 1'b0;
    bus.m_size  = '0;
    bus.m_wstrb = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (gnt_valid) begin
      if (gnt == OWN_D) begin
        bus.m_wr    = bus.d_wr;
        bus.m_size  = bus.d_size;
        bus.m_wstrb = bus.d_wstrb;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
      end else begin
        bus.m_wr    = bus.i_wr;
        bus.m_size  = bus.i_size;
        bus.m_wstrb = bus.i_wstrb;
        bus.m_addr  = bus.i_addr;
        bus.m_wdata = bus.i_wdata;
      end
    end

    bus.i_addr_ok = hs & (gnt == OWN_I);
    bus.d_addr_ok = hs & (gnt == OWN_D);
    bus.i_data_ok = pop & ~head_is_d;
    bus.d_data_ok = pop & head_is_d;
    bus.i_rdata   = bus.m_rdata;
    bus.d_rdata   = bus.m_rdata;
    bus.busy      = (count_q != '0);
  end

  // Next state: lock, owner FIFO, occupancy and starvation counter
  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (m_req_c && !bus.m_addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = gnt;
    end else if (hs) begin
      lock_d = 1'b0;
    end

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (hs) begin
      fifo_d[wptr_q] = (gnt == OWN_D);
      wptr_d         = next_ptr(wptr_q);
    end
    if (pop) begin
      rptr_d = next_ptr(rptr_q);
    end

    count_d = count_q;
    case ({hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (!bus.i_req || (hs && gnt == OWN_I)) begin
      starve_d = '0;
    end else if (hs && gnt == OWN_D && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_I;
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      starve_q     <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
    end
  end
endmodule
